qslave2908: RTL and testbench

- QBUS slave (responder) for a small block of device word registers in the I/O page, behind Am2908 bus transceivers.
- Decodes the latched address and services DATI, DATO, DATOB and DATIO(B) cycles.
- Drives the read-data strobe and bus-enable controls to the Am2908s, and generates TRPLY.
- Presents a simple synchronous register-file port to the device core.

---
 rtl/qslave2908_if.sv | 35 +++
 rtl/qslave2908.sv | 184 ++++++++++++++++++
 tb/tb_qslave2908.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qslave2908_if.sv
// QBUS/Am2908 bus-side and register-file-side signals of the qslave2908 responder.
// slave = responder view, master = bus master plus device-core view.
interface qslave2908_if #(
    parameter int NREG_LOG2 = 3
);
    logic                 RSYNC;
    logic                 RDIN;
    logic                 RDOUT;
    logic                 RWTBT;
    logic                 RBS7;
    logic [15:0]          RDAL;
    logic                 TRPLY;
    logic                 DALst;
    logic                 DALbe;
    logic [15:0]          dal_out;
    logic [NREG_LOG2-1:0] reg_sel;
    logic                 reg_rd;
    logic [15:0]          reg_rdata;
    logic                 reg_wr;
    logic [1:0]           reg_be;
    logic [15:0]          reg_wdata;
    logic                 selected;

    modport slave (
        input  RSYNC, RDIN, RDOUT, RWTBT, RBS7, RDAL, reg_rdata,
        output TRPLY, DALst, DALbe, dal_out, reg_sel, reg_rd, reg_wr,
               reg_be, reg_wdata, selected
    );

    modport master (
        output RSYNC, RDIN, RDOUT, RWTBT, RBS7, RDAL, reg_rdata,
        input  TRPLY, DALst, DALbe, dal_out, reg_sel, reg_rd, reg_wr,
               reg_be, reg_wdata, selected
    );
endinterface

// File: rtl/qslave2908.sv
// QBUS slave for 2**NREG_LOG2 I/O-page word registers behind Am2908 transceivers.
// DIN->TRPLY 5+DATA_SETUP clks, DOUT->TRPLY 3 clks; reply is held until the master negates its strobe.
module qslave2908 #(
    parameter logic [12:0] BASE_ADDR  = 13'o17760,
    parameter int          NREG_LOG2  = 3,
    parameter int          DATA_SETUP = 2
) (
    input  logic        clk,
    input  logic        RINIT,
    qslave2908_if.slave bus
);
    localparam int CW = (DATA_SETUP < 2) ? 1 : $clog2(DATA_SETUP + 1);
    localparam int AH = NREG_LOG2 + 1;

    typedef enum logic [9:0] {
        IDLE        = 10'b00_0000_0001,
        DECODE      = 10'b00_0000_0010,
        SELECTED    = 10'b00_0000_0100,
        READ_FETCH  = 10'b00_0000_1000,
        READ_LOAD   = 10'b00_0001_0000,
        READ_SETUP  = 10'b00_0010_0000,
        READ_REPLY  = 10'b00_0100_0000,
        WRITE       = 10'b00_1000_0000,
        WRITE_REPLY = 10'b01_0000_0000,
        SYNC_CLEAR  = 10'b10_0000_0000
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync_ff;
    logic [1:0]           r_din_ff;
    logic [1:0]           r_dout_ff;
    logic                 r_a0;
    logic                 r_wtbt;
    logic [CW-1:0]        r_cnt;
    logic                 r_trply;
    logic                 r_dalst;
    logic                 r_dalbe;
    logic [15:0]          r_dal;
    logic [NREG_LOG2-1:0] r_sel;
    logic                 r_rd;
    logic                 r_wr;
    logic [1:0]           r_be;
    logic [15:0]          r_wdata;
    logic                 r_selected;

    logic w_ssync;
    logic w_sdin;
    logic w_sdout;
    logic w_addr_hit;

    assign w_ssync    = r_sync_ff[1];
    assign w_sdin     = r_din_ff[1];
    assign w_sdout    = r_dout_ff[1];
    assign w_addr_hit = bus.RBS7 && (bus.RDAL[12:AH] == BASE_ADDR[12:AH]);

    always_ff @(posedge clk or posedge RINIT) begin
        if (RINIT) begin
            r_sync_ff <= 2'b00;
            r_din_ff  <= 2'b00;
            r_dout_ff <= 2'b00;
        end else begin
            r_sync_ff <= {r_sync_ff[0], bus.RSYNC};
            r_din_ff  <= {r_din_ff[0], bus.RDIN};
            r_dout_ff <= {r_dout_ff[0], bus.RDOUT};
        end
    end

    always_ff @(posedge clk or posedge RINIT) begin
        if (RINIT) begin
            r_state    <= IDLE;
            r_a0       <= 1'b0;
            r_wtbt     <= 1'b0;
            r_cnt      <= '0;
            r_trply    <= 1'b0;
            r_dalst    <= 1'b0;
            r_dalbe    <= 1'b0;
            r_dal      <= 16'h0000;
            r_sel      <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_be       <= 2'b00;
            r_wdata    <= 16'h0000;
            r_selected <= 1'b0;
        end else begin
            // strobes are single-cycle; an abort lets an in-flight pulse finish
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            if (!w_ssync && r_state != IDLE && r_state != SYNC_CLEAR) begin
                r_state    <= IDLE;
                r_trply    <= 1'b0;
                r_dalbe    <= 1'b0;
                r_dalst    <= 1'b0;
                r_selected <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ssync) r_state <= DECODE;
                    end
                    DECODE: begin
                        if (w_addr_hit) begin
                            r_sel      <= bus.RDAL[NREG_LOG2:1];
                            r_a0       <= bus.RDAL[0];
                            r_selected <= 1'b1;
                            r_state    <= SELECTED;
                        end else begin
                            r_selected <= 1'b0;
                            r_state    <= SYNC_CLEAR;
                        end
                    end
                    SELECTED: begin
                        if (w_sdin) begin
                            r_rd    <= 1'b1;
                            r_state <= READ_FETCH;
                        end else if (w_sdout) begin
                            r_wdata <= bus.RDAL;
                            r_wtbt  <= bus.RWTBT;
                            r_state <= WRITE;
                        end
                    end
                    READ_FETCH: begin
                        r_state <= READ_LOAD;
                    end
                    READ_LOAD: begin
                        r_dal   <= bus.reg_rdata;
                        r_dalst <= 1'b1;
                        r_cnt   <= CW'(DATA_SETUP);
                        r_state <= READ_SETUP;
                    end
                    READ_SETUP: begin
                        // first pass enables the drivers; TRPLY follows DATA_SETUP cycles later
                        r_dalst <= 1'b0;
                        r_dalbe <= 1'b1;
                        if (r_cnt == '0) begin
                            r_trply <= 1'b1;
                            r_state <= READ_REPLY;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    READ_REPLY: begin
                        if (!w_sdin) begin
                            r_trply <= 1'b0;
                            r_dalbe <= 1'b0;
                            r_state <= SELECTED;
                        end
                    end
                    WRITE: begin
                        r_wr    <= 1'b1;
                        r_be    <= r_wtbt ? (r_a0 ? 2'b10 : 2'b01) : 2'b11;
                        r_trply <= 1'b1;
                        r_state <= WRITE_REPLY;
                    end
                    WRITE_REPLY: begin
                        if (!w_sdout) begin
                            r_trply <= 1'b0;
                            r_state <= SELECTED;
                        end
                    end
                    SYNC_CLEAR: begin
                        if (!w_ssync) r_state <= IDLE;
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_trply    <= 1'b0;
                        r_dalbe    <= 1'b0;
                        r_dalst    <= 1'b0;
                        r_selected <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.TRPLY     = r_trply;
    assign bus.DALst     = r_dalst;
    assign bus.DALbe     = r_dalbe;
    assign bus.dal_out   = r_dal;
    assign bus.reg_sel   = r_sel;
    assign bus.reg_rd    = r_rd;
    assign bus.reg_wr    = r_wr;
    assign bus.reg_be    = r_be;
    assign bus.reg_wdata = r_wdata;
    assign bus.selected  = r_selected;
endmodule

// File: tb/tb_qslave2908.sv
// Bench for qslave2908: scheduled random QBUS master, register-file stub and a timeline model
// that predicts every output interval from the strobe timing rules.
module tb_qslave2908;
    localparam int          NREG_LOG2 = 3;
    localparam int          NREG      = 8;
    localparam int          DS        = 2;
    localparam logic [12:0] BASE      = 13'o17760;
    localparam int          NCYC      = 8192;

    logic clk;
    logic RINIT;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   next_free;
    bit   cmp_on;
    bit   core_load;

    qslave2908_if #(.NREG_LOG2(NREG_LOG2)) bus ();

    qslave2908 #(.BASE_ADDR(BASE), .NREG_LOG2(NREG_LOG2), .DATA_SETUP(DS)) dut (
        .clk   (clk),
        .RINIT (RINIT),
        .bus   (bus)
    );

    bit          e_trply [NCYC];
    bit          e_dalst [NCYC];
    bit          e_dalbe [NCYC];
    bit          e_sel   [NCYC];
    bit          e_rd    [NCYC];
    bit          e_wr    [NCYC];
    logic [15:0] v_dal   [NCYC];
    logic [2:0]  v_sel   [NCYC];
    logic [1:0]  v_be    [NCYC];
    logic [15:0] v_wd    [NCYC];
    logic [15:0] model_mem [NREG];
    logic [15:0] core_mem  [NREG];

    int rd_cnt, wr_cnt, rises, last_rise;
    bit trply_q;

    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        return (i == 2) ? 16'hA5C3 : 16'(16'h1F0F + i * 16'h0321);
    endfunction

    // device-core register file stub
    always @(posedge clk) begin
        if (core_load) begin
            for (int i = 0; i < NREG; i++) core_mem[i] <= init_val(i);
        end else begin
            if (bus.reg_rd) bus.reg_rdata <= core_mem[bus.reg_sel];
            if (bus.reg_wr) begin
                if (bus.reg_be[0]) core_mem[bus.reg_sel][7:0]  <= bus.reg_wdata[7:0];
                if (bus.reg_be[1]) core_mem[bus.reg_sel][15:8] <= bus.reg_wdata[15:8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && cyc < NCYC) begin
            chk("trply",    bus.TRPLY,    e_trply[cyc]);
            chk("dalst",    bus.DALst,    e_dalst[cyc]);
            chk("dalbe",    bus.DALbe,    e_dalbe[cyc]);
            chk("selected", bus.selected, e_sel[cyc]);
            chk("reg_rd",   bus.reg_rd,   e_rd[cyc]);
            chk("reg_wr",   bus.reg_wr,   e_wr[cyc]);
            if (e_rd[cyc] || e_wr[cyc]) chk("reg_sel", bus.reg_sel, v_sel[cyc]);
            if (e_wr[cyc]) begin
                chk("reg_be",    bus.reg_be,    v_be[cyc]);
                chk("reg_wdata", bus.reg_wdata, v_wd[cyc]);
            end
            if (e_dalbe[cyc]) chk("dal_out", bus.dal_out, v_dal[cyc]);
        end
        if (bus.reg_rd) rd_cnt++;
        if (bus.reg_wr) wr_cnt++;
        if (bus.TRPLY && !trply_q) begin
            rises++;
            last_rise = cyc;
        end
        trply_q = bus.TRPLY;
    end

    function automatic void mark(input int which, input int a, input int b);
        for (int c = a; c < b; c++) begin
            if (c >= 0 && c < NCYC) begin
                case (which)
                    0: e_trply[c] = 1'b1;
                    1: e_dalst[c] = 1'b1;
                    2: e_dalbe[c] = 1'b1;
                    3: e_sel[c]   = 1'b1;
                    4: e_rd[c]    = 1'b1;
                    default: e_wr[c] = 1'b1;
                endcase
            end
        end
    endfunction

    function automatic int rnd(input int n);
        return int'($urandom_range(n, 0));
    endfunction

    // drive so the new value is first sampled by posedge number e
    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    // kind: 0 DATI, 1 DATO(B), 2 DATIO(B), 3 DATI aborted in data setup, 4 RINIT during read reply
    task automatic do_cycle(input int kind, input bit bs7, input logic [12:0] addr,
                            input logic [15:0] wd, input bit wtbt, output int ts);
        int S, D, E, O, F, N, sel, rend;
        bit hit;
        logic [1:0] be;
        hit = bs7 && ((int'(addr) >> (NREG_LOG2 + 1)) == (int'(BASE) >> (NREG_LOG2 + 1)));
        sel = (int'(addr) >> 1) % NREG;
        be  = wtbt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        S = (next_free > cyc + 1) ? next_free : cyc + 1;
        D = S + 4 + rnd(3);
        E = D + 6 + DS + rnd(3);
        O = (kind == 2) ? E + 2 + rnd(3) : S + 4 + rnd(3);
        F = O + 4 + rnd(3);
        case (kind)
            0:       N = E + 1 + rnd(3);
            3:       N = D + 3 + rnd(2);
            4:       N = D + 9;
            default: N = F + 1 + rnd(3);
        endcase
        if (hit) begin
            mark(3, S + 3, (kind == 4) ? D + 9 : N + 2);
            if (kind != 1) begin
                rend = (kind == 3) ? N + 2 : (kind == 4) ? D + 9 : E + 2;
                mark(4, D + 2, D + 3);
                v_sel[D + 2] = sel[2:0];
                mark(1, D + 4, D + 5);
                mark(2, D + 5, rend);
                for (int c = D + 5; c < rend; c++) v_dal[c] = model_mem[sel];
                if (kind != 3) mark(0, D + 5 + DS, rend);
            end
            if (kind == 1 || kind == 2) begin
                mark(5, O + 3, O + 4);
                v_sel[O + 3] = sel[2:0];
                v_be[O + 3]  = be;
                v_wd[O + 3]  = wd;
                mark(0, O + 3, F + 2);
                if (be[0]) model_mem[sel][7:0]  = wd[7:0];
                if (be[1]) model_mem[sel][15:8] = wd[15:8];
            end
        end
        ts = (kind == 1) ? O : D;

        at_edge(S);
        bus.RSYNC = 1'b1; bus.RBS7 = bs7; bus.RDAL = {3'b000, addr}; bus.RWTBT = 1'b0;
        if (kind != 1) begin
            at_edge(D);
            bus.RDIN = 1'b1;
        end
        if (kind == 0 || kind == 2) begin
            at_edge(E);
            bus.RDIN = 1'b0;
        end
        if (kind == 1 || kind == 2) begin
            at_edge(O);
            bus.RDOUT = 1'b1; bus.RDAL = wd; bus.RWTBT = wtbt;
            at_edge(F);
            bus.RDOUT = 1'b0; bus.RWTBT = 1'b0;
        end
        if (kind == 4) begin
            at_edge(D + 9);
            #5 RINIT = 1'b1;
            #1 chk("rinit_outputs",
                   {bus.TRPLY, bus.DALst, bus.DALbe, bus.selected, bus.reg_rd, bus.reg_wr,
                    bus.reg_be, bus.reg_sel, bus.dal_out, bus.reg_wdata}, 64'd0);
            #5 bus.RSYNC = 1'b0; bus.RDIN = 1'b0;
            RINIT = 1'b0;
            next_free = D + 10;
        end else begin
            at_edge(N);
            bus.RSYNC = 1'b0; bus.RDIN = 1'b0;
            next_free = N + 2;
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        #(NCYC * 50);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, r0, w0, k0, kind;
        logic [12:0] addr;
        bit bs7, wtbt;
        cyc = 0; n_checks = 0; n_errors = 0; cmp_on = 1'b0; core_load = 1'b1;
        rd_cnt = 0; wr_cnt = 0; rises = 0; last_rise = 0; trply_q = 1'b0;
        RINIT = 1'b0;
        bus.RSYNC = 1'b0; bus.RDIN = 1'b0; bus.RDOUT = 1'b0; bus.RWTBT = 1'b0;
        bus.RBS7 = 1'b0; bus.RDAL = 16'h0000; bus.reg_rdata = 16'h0000;
        for (int i = 0; i < NREG; i++) model_mem[i] = init_val(i);
        #1 RINIT = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {bus.TRPLY, bus.DALst, bus.DALbe, bus.selected, bus.reg_rd, bus.reg_wr,
             bus.reg_be, bus.reg_sel, bus.dal_out, bus.reg_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        RINIT = 1'b0; core_load = 1'b0; cmp_on = 1'b1;
        next_free = cyc + 2;

        // DATI at BASE+4
        r0 = rd_cnt;
        do_cycle(0, 1'b1, 13'o17764, 16'h0000, 1'b0, ts);
        settle();
        chk("dati_dal_out", bus.dal_out, 16'hA5C3);
        chk("dati_reg_sel", bus.reg_sel, 3'd2);
        chk("dati_latency", last_rise - ts, 7);
        chk("dati_rd_pulses", rd_cnt - r0, 1);

        // DATO word at BASE+2
        w0 = wr_cnt;
        do_cycle(1, 1'b1, 13'o17762, 16'h1234, 1'b0, ts);
        settle();
        chk("dato_wdata", bus.reg_wdata, 16'h1234);
        chk("dato_be", bus.reg_be, 2'b11);
        chk("dato_sel", bus.reg_sel, 3'd1);
        chk("dato_latency", last_rise - ts, 3);
        chk("dato_wr_pulses", wr_cnt - w0, 1);

        // DATOB odd then even byte
        do_cycle(1, 1'b1, 13'o17767, 16'hBEEF, 1'b1, ts);
        settle();
        chk("datob_odd_be", bus.reg_be, 2'b10);
        chk("datob_odd_sel", bus.reg_sel, 3'd3);
        do_cycle(1, 1'b1, 13'o17766, 16'h5A69, 1'b1, ts);
        settle();
        chk("datob_even_be", bus.reg_be, 2'b01);

        // unselected cycles
        r0 = rd_cnt; w0 = wr_cnt; k0 = rises;
        do_cycle(0, 1'b1, 13'o17700, 16'h0000, 1'b0, ts);
        do_cycle(1, 1'b0, 13'o17764, 16'hFFFF, 1'b0, ts);
        settle();
        chk("nosel_rd", rd_cnt - r0, 0);
        chk("nosel_wr", wr_cnt - w0, 0);
        chk("nosel_trply", rises - k0, 0);

        // DATIO under one SYNC
        r0 = rd_cnt; w0 = wr_cnt; k0 = rises;
        do_cycle(2, 1'b1, 13'o17764, 16'h0F1E, 1'b0, ts);
        settle();
        chk("datio_rd", rd_cnt - r0, 1);
        chk("datio_wr", wr_cnt - w0, 1);
        chk("datio_trply", rises - k0, 2);

        // RINIT during reply, then a normal read
        do_cycle(4, 1'b1, 13'o17762, 16'h0000, 1'b0, ts);
        settle();
        do_cycle(0, 1'b1, 13'o17762, 16'h0000, 1'b0, ts);
        settle();
        chk("post_rinit_dal", bus.dal_out, 16'h1234);

        // SYNC abort during data setup
        k0 = rises;
        do_cycle(3, 1'b1, 13'o17764, 16'h0000, 1'b0, ts);
        settle();
        chk("abort_trply", rises - k0, 0);

        for (int t = 0; t < 40; t++) begin
            kind = rnd(5);
            kind = (kind < 2) ? 0 : (kind < 4) ? 1 : (kind == 4) ? 2 : 3;
            bs7  = 1'b1;
            wtbt = 1'(rnd(1));
            addr = 13'(BASE + 13'(rnd(NREG - 1) * 2) + 13'(rnd(1)));
            if (rnd(4) == 0) begin
                if (rnd(1) == 1) begin
                    bs7 = 1'b0;
                end else begin
                    addr = 13'(rnd(8191));
                    if ((int'(addr) >> 4) == (int'(BASE) >> 4)) addr = addr ^ 13'h0800;
                end
            end
            do_cycle(kind, bs7, addr, 16'($urandom), wtbt, ts);
        end
        settle();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
